// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 codes, 2-bit counter encodings, opcodes and the
// saturating counter update used by the BHT.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != 2'(ST)))
      nxt = cnt + 2'd1;
    else if (!taken && (cnt != 2'(SNT)))
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters: one combinational read port
// and one saturating-update write port. Reset loads weakly-not-taken everywhere.
module bht_table
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] cnt_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 2'(WNT);
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= sat_update(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

  // Read is pre-update: a same-cycle write to this index is not bypassed.
  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predict_resolve.sv
// Gshare direction predictor (ID side) and branch/JALR resolver (EX side) with a
// registered one-cycle redirect and resolve statistics.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_is_branch,
  input  logic             id_is_jal,
  output logic             id_pred_taken,
  output logic [XLEN-1:0]  id_pred_target,
  output logic [IDX_W-1:0] id_pred_idx,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_branch_type,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic             ex_pred_taken,
  input  logic [IDX_W-1:0] ex_pred_idx,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             redirect_q, redirect_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [1:0]       bht_rd_cnt;
  logic             cond_known, cond_taken;
  logic             br_resolve, jalr_resolve, br_mispred;
  logic [XLEN-1:0]  br_target, jalr_sum;
  logic signed [XLEN-1:0] rs1_s, rs2_s;

  // ID: gshare lookup
  assign id_pred_idx    = id_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign id_pred_taken  = id_is_jal | (id_is_branch & bht_rd_cnt[1]);
  assign id_pred_target = id_pc + id_imm;

  bht_table #(.IDX_W(IDX_W)) u_bht (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rd_idx_i   (id_pred_idx),
    .rd_cnt_o   (bht_rd_cnt),
    .wr_en_i    (br_resolve),
    .wr_idx_i   (ex_pred_idx),
    .wr_taken_i (cond_taken)
  );

  // EX: condition evaluation
  assign rs1_s = ex_rs1;
  assign rs2_s = ex_rs2;

  always_comb begin
    cond_known = 1'b1;
    cond_taken = 1'b0;
    case (ex_branch_type)
      BR_BEQ:  cond_taken = (ex_rs1 == ex_rs2);
      BR_BNE:  cond_taken = (ex_rs1 != ex_rs2);
      BR_BLT:  cond_taken = (rs1_s <  rs2_s);
      BR_BGE:  cond_taken = (rs1_s >= rs2_s);
      BR_BLTU: cond_taken = (ex_rs1 <  ex_rs2);
      BR_BGEU: cond_taken = (ex_rs1 >= ex_rs2);
      default: cond_known = 1'b0;
    endcase
  end

  assign jalr_resolve = ex_valid & ex_is_jalr;
  assign br_resolve   = ex_valid & ex_is_branch & ~ex_is_jalr & ~ex_is_jal & cond_known;
  assign br_mispred   = br_resolve & (cond_taken != ex_pred_taken);
  assign br_target    = ex_pc + ex_imm;
  assign jalr_sum     = ex_rs1 + ex_imm;

  always_comb begin
    ghr_d         = ghr_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    mis_cnt_d     = mis_cnt_q;
    if (jalr_resolve) begin
      redirect_d    = 1'b1;
      redirect_pc_d = {jalr_sum[XLEN-1:1], 1'b0};
      mis_cnt_d     = mis_cnt_q + CNT_W'(1);
    end else if (br_resolve) begin
      ghr_d    = {ghr_q[GHR_W-2:0], cond_taken};
      br_cnt_d = br_cnt_q + CNT_W'(1);
      if (br_mispred) begin
        redirect_d    = 1'b1;
        redirect_pc_d = cond_taken ? br_target : (ex_pc + XLEN'(4));
        mis_cnt_d     = mis_cnt_q + CNT_W'(1);
      end
    end
  end

  // Resolve -> redirect/stat register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      ghr_q         <= ghr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0], bht_rd_cnt[0]};

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: hand-computed predictions, redirects,
// GHR evolution (observed via id_pred_idx) and statistics.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_pc, id_imm;
  logic        id_is_branch, id_is_jal;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic [5:0]  id_pred_idx;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_branch_type;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic        ex_pred_taken;
  logic [5:0]  ex_pred_idx;
  logic        redirect;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_resolve dut (
    .clk(clk), .rst_n(rst_n),
    .id_pc(id_pc), .id_imm(id_imm), .id_is_branch(id_is_branch), .id_is_jal(id_is_jal),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target), .id_pred_idx(id_pred_idx),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_branch_type(ex_branch_type),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx),
    .redirect(redirect), .redirect_pc(redirect_pc), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_branch_type = 3'b000; ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_pred_taken = 1'b0; ex_pred_idx = '0;
  endtask

  task automatic ex_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic pred, input logic [5:0] idx);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_branch_type = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = a; ex_rs2 = b;
    ex_pred_taken = pred; ex_pred_idx = idx;
  endtask

  task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] mis);
    chk({tag, ".br_count"}, br_count, br);
    chk({tag, ".mispred_count"}, mispred_count, mis);
  endtask

  initial begin
    rst_n = 1'b0;
    id_pc = 32'h100; id_imm = 32'h20; id_is_branch = 1'b1; id_is_jal = 1'b0;
    ex_idle();
    tick(); tick();
    rst_n = 1'b1;

    // 1. reset state
    chk("rst.pred_taken", id_pred_taken, 1'b0);
    chk("rst.pred_idx", id_pred_idx, 6'd0);
    chk("rst.pred_target", id_pred_target, 32'h120);
    chk("rst.redirect", redirect, 1'b0);
    chk("rst.redirect_pc", redirect_pc, 32'h0);
    stats("rst", 0, 0);

    // 2. BEQ taken, predicted not-taken -> redirect to target
    ex_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 6'd5);
    tick();
    chk("beq1.redirect", redirect, 1'b1);
    chk("beq1.redirect_pc", redirect_pc, 32'h120);
    stats("beq1", 1, 1);
    ex_idle();
    id_pc = 32'h10;  // pc[7:2]=4, ghr=1 -> idx 5
    #1;
    chk("beq1.lookup_idx", id_pred_idx, 6'd5);
    chk("beq1.lookup_taken", id_pred_taken, 1'b1);
    tick();
    chk("idle.redirect", redirect, 1'b0);

    // 3. two more taken at idx 5, predicted correctly -> saturate at 11
    ex_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 6'd5);
    tick();
    chk("beq2.redirect", redirect, 1'b0);
    stats("beq2", 2, 1);
    tick();
    chk("beq3.redirect", redirect, 1'b0);
    stats("beq3", 3, 1);
    // BNE not taken, predicted taken -> fall-through redirect, counter 11->10
    ex_branch(3'b001, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 6'd5);
    tick();
    chk("bne.redirect", redirect, 1'b1);
    chk("bne.redirect_pc", redirect_pc, 32'h104);
    stats("bne", 4, 2);
    ex_idle();
    id_pc = 32'h2C;  // pc[7:2]=0xB, ghr=0xE -> idx 5
    #1;
    chk("sat.lookup_idx", id_pred_idx, 6'd5);
    chk("sat.lookup_taken", id_pred_taken, 1'b1);
    tick();

    // 4. BLT signed taken, BLTU same operands not taken
    ex_branch(3'b100, 32'h200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b0, 6'd7);
    tick();
    chk("blt.redirect", redirect, 1'b1);
    chk("blt.redirect_pc", redirect_pc, 32'h1F0);
    stats("blt", 5, 3);
    ex_idle(); tick();
    ex_branch(3'b110, 32'h200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b1, 6'd8);
    tick();
    chk("bltu.redirect", redirect, 1'b1);
    chk("bltu.redirect_pc", redirect_pc, 32'h204);
    stats("bltu", 6, 4);
    ex_idle(); tick();

    // 5. JALR: redirect with LSB cleared, no BHT/GHR/br_count change
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_pc = 32'h300; ex_rs1 = 32'h203; ex_imm = 32'd4;
    ex_pred_idx = 6'd9;
    tick();
    chk("jalr.redirect", redirect, 1'b1);
    chk("jalr.redirect_pc", redirect_pc, 32'h206);
    stats("jalr", 6, 5);
    ex_idle();
    id_pc = 32'h0;
    #1;
    chk("jalr.ghr_idx", id_pred_idx, 6'h3A);
    id_is_branch = 1'b0; id_is_jal = 1'b1;
    #1;
    chk("jal.pred_taken", id_pred_taken, 1'b1);
    id_is_branch = 1'b1; id_is_jal = 1'b0;
    tick();

    // funct3 010 is ignored
    ex_branch(3'b010, 32'h400, 32'h40, 32'd1, 32'd2, 1'b0, 6'd0);
    tick();
    chk("f3_010.redirect", redirect, 1'b0);
    stats("f3_010", 6, 5);
    chk("f3_010.ghr_idx", id_pred_idx, 6'h3A);

    // 6. same-cycle update and lookup on idx 0x3A sees the old counter (01)
    ex_branch(3'b000, 32'h500, 32'h80, 32'd3, 32'd3, 1'b0, 6'h3A);
    id_pc = 32'h0;
    #1;
    chk("bypass.lookup_taken", id_pred_taken, 1'b0);
    tick();
    chk("bypass.redirect", redirect, 1'b1);
    chk("bypass.redirect_pc", redirect_pc, 32'h580);
    // reset during the redirect cycle with another mispredict pending
    rst_n = 1'b0;
    ex_branch(3'b001, 32'h600, 32'h10, 32'd1, 32'd2, 1'b0, 6'h3A);
    tick();
    chk("mrst.redirect", redirect, 1'b0);
    chk("mrst.redirect_pc", redirect_pc, 32'h0);
    stats("mrst", 0, 0);
    rst_n = 1'b1;
    ex_idle();
    id_pc = 32'hE8;  // pc[7:2]=0x3A, ghr=0
    #1;
    chk("mrst.lookup_idx", id_pred_idx, 6'h3A);
    chk("mrst.lookup_taken", id_pred_taken, 1'b0);
    tick();
    chk("mrst.idle_redirect", redirect, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
